// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing for a 5-stage core: RAW bubbles, taken-redirect squash,
// global freeze, stall/flush performance counters and a stall watchdog.
module pipeline_hazard_controller #(
    parameter int unsigned FORWARDING = 1,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_STALL  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_en,
    input  logic             mem_busy,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_usesRs,
    input  logic             id_usesRt,
    input  logic [4:0]       ex_registerWriteAddress,
    input  logic             ex_ifWriteRegsFile,
    input  logic             ex_memOutOrAluOutWriteBackToRegFile,
    input  logic [4:0]       mem_registerWriteAddress,
    input  logic             mem_ifWriteRegsFile,
    input  logic             ex_shouldJumpOrBranch,
    output logic             pipe_en,
    output logic             pc_write_en,
    output logic             pc_select_branch,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_shouldStall,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             stall_timeout
);

    localparam int unsigned ConsecW = $clog2(MAX_STALL + 1);
    localparam logic [ConsecW-1:0] ConsecMax = ConsecW'(MAX_STALL);

    typedef enum logic [2:0] {StInit, StRun, StStall, StFlush, StFrozen} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;
    logic [ConsecW-1:0] consec_q, consec_d;
    logic               timeout_q, timeout_d;

    logic ex_match, mem_match, hz, freeze, redirect;

    always_comb begin
        ex_match = ex_ifWriteRegsFile &&
            ((id_usesRs && (id_rs != 5'd0) && (id_rs == ex_registerWriteAddress)) ||
             (id_usesRt && (id_rt != 5'd0) && (id_rt == ex_registerWriteAddress)));
        mem_match = mem_ifWriteRegsFile &&
            ((id_usesRs && (id_rs != 5'd0) && (id_rs == mem_registerWriteAddress)) ||
             (id_usesRt && (id_rt != 5'd0) && (id_rt == mem_registerWriteAddress)));
        // With forwarding only a load in EX cannot supply its result in time.
        hz = (FORWARDING != 0) ? (ex_memOutOrAluOutWriteBackToRegFile && ex_match)
                               : (ex_match || mem_match);
        freeze   = !cpu_en || mem_busy;
        redirect = ex_shouldJumpOrBranch;
    end

    always_comb begin
        pipe_en          = 1'b0;
        pc_write_en      = 1'b0;
        pc_select_branch = 1'b0;
        if_id_write_en   = 1'b0;
        if_id_flush      = 1'b0;
        id_shouldStall   = 1'b0;
        state_d          = state_q;
        stall_cycles_d   = stall_cycles_q;
        flush_count_d    = flush_count_q;
        consec_d         = consec_q;

        if (state_q == StInit) begin
            state_d = StRun;
        end else if (freeze) begin
            state_d = StFrozen;
        end else if (redirect) begin
            pipe_en          = 1'b1;
            pc_write_en      = 1'b1;
            pc_select_branch = 1'b1;
            if_id_write_en   = 1'b1;
            if_id_flush      = 1'b1;
            id_shouldStall   = 1'b1;
            state_d          = StFlush;
            if (flush_count_q != '1) flush_count_d = flush_count_q + CNT_W'(1);
        end else if (hz) begin
            pipe_en        = 1'b1;
            id_shouldStall = 1'b1;
            state_d        = StStall;
            if (stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
            if (consec_q < ConsecMax) consec_d = consec_q + ConsecW'(1);
        end else begin
            pipe_en        = 1'b1;
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
            state_d        = StRun;
            consec_d       = '0;
        end

        timeout_d = timeout_q || (consec_d == ConsecMax);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StInit;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
            consec_q       <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
            consec_q       <= consec_d;
            timeout_q      <= timeout_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign flush_count   = flush_count_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: two controller instances (forwarding / no forwarding) share
// stimulus; whichever is out of reset is checked against queued expectations.
module tb_pipeline_hazard_controller;

    logic clk = 1'b1;
    logic rstA, rstB;
    logic cpu_en, mem_busy;
    logic [4:0] id_rs, id_rt, ex_wa, mem_wa;
    logic id_usesRs, id_usesRt, ex_w, ex_load, mem_w, br;

    logic a_pipe, a_pcw, a_sel, a_ifw, a_fl, a_st, a_to;
    logic b_pipe, b_pcw, b_sel, b_ifw, b_fl, b_st, b_to;
    logic [31:0] a_sc, a_fc, b_sc, b_fc;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.FORWARDING(1), .CNT_W(32), .MAX_STALL(16)) dutA (
        .clk(clk), .rst_n(rstA), .cpu_en(cpu_en), .mem_busy(mem_busy),
        .id_rs(id_rs), .id_rt(id_rt), .id_usesRs(id_usesRs), .id_usesRt(id_usesRt),
        .ex_registerWriteAddress(ex_wa), .ex_ifWriteRegsFile(ex_w),
        .ex_memOutOrAluOutWriteBackToRegFile(ex_load),
        .mem_registerWriteAddress(mem_wa), .mem_ifWriteRegsFile(mem_w),
        .ex_shouldJumpOrBranch(br), .pipe_en(a_pipe), .pc_write_en(a_pcw),
        .pc_select_branch(a_sel), .if_id_write_en(a_ifw), .if_id_flush(a_fl),
        .id_shouldStall(a_st), .stall_cycles(a_sc), .flush_count(a_fc),
        .stall_timeout(a_to)
    );

    pipeline_hazard_controller #(.FORWARDING(0), .CNT_W(32), .MAX_STALL(2)) dutB (
        .clk(clk), .rst_n(rstB), .cpu_en(cpu_en), .mem_busy(mem_busy),
        .id_rs(id_rs), .id_rt(id_rt), .id_usesRs(id_usesRs), .id_usesRt(id_usesRt),
        .ex_registerWriteAddress(ex_wa), .ex_ifWriteRegsFile(ex_w),
        .ex_memOutOrAluOutWriteBackToRegFile(ex_load),
        .mem_registerWriteAddress(mem_wa), .mem_ifWriteRegsFile(mem_w),
        .ex_shouldJumpOrBranch(br), .pipe_en(b_pipe), .pc_write_en(b_pcw),
        .pc_select_branch(b_sel), .if_id_write_en(b_ifw), .if_id_flush(b_fl),
        .id_shouldStall(b_st), .stall_cycles(b_sc), .flush_count(b_fc),
        .stall_timeout(b_to)
    );

    typedef struct {
        bit          useB;
        logic [5:0]  ctrl;   // {pipe_en, pc_we, pc_sel, if_id_we, if_id_flush, stall}
        logic [31:0] sc;
        logic [31:0] fc;
        logic        to;
        string       name;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;
    bit allIssued = 1'b0;

    localparam logic [5:0] CInit = 6'b000000;
    localparam logic [5:0] CRun  = 6'b110100;
    localparam logic [5:0] CStl  = 6'b100001;
    localparam logic [5:0] CRdr  = 6'b111111;

    // Monitor: every cycle the design presents its outputs; check one entry.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [70:0] got, want;
            e = q.pop_front();
            if (e.useB) got = {b_pipe, b_pcw, b_sel, b_ifw, b_fl, b_st, b_sc, b_fc, b_to};
            else        got = {a_pipe, a_pcw, a_sel, a_ifw, a_fl, a_st, a_sc, a_fc, a_to};
            want = {e.ctrl, e.sc, e.fc, e.to};
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL %s: got ctrl=%b sc=%0d fc=%0d to=%b, want ctrl=%b sc=%0d fc=%0d to=%b",
                         e.name, got[70:65], got[64:33], got[32:1], got[0],
                         want[70:65], want[64:33], want[32:1], want[0]);
            end
        end
    end

    task automatic clr();
        cpu_en = 1'b1; mem_busy = 1'b0; br = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_usesRs = 1'b0; id_usesRt = 1'b0;
        ex_wa = 5'd0; ex_w = 1'b0; ex_load = 1'b0; mem_wa = 5'd0; mem_w = 1'b0;
    endtask

    task automatic setEx(input logic [4:0] wa, input logic w, input logic ld);
        ex_wa = wa; ex_w = w; ex_load = ld;
    endtask

    task automatic setId(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                         input logic urt);
        id_rs = rs; id_usesRs = urs; id_rt = rt; id_usesRt = urt;
    endtask

    // Queue the expectation for the current input set, then advance a cycle.
    task automatic cyc(input string nm, input bit useB, input logic [5:0] c,
                       input int sc, input int fc, input bit to);
        exp_t e;
        e.useB = useB; e.ctrl = c; e.sc = sc; e.fc = fc; e.to = to; e.name = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstA = 1'b1; rstB = 1'b1;
        clr();
        #1;
        rstA = 1'b0; rstB = 1'b0;
        cyc("reset_held", 0, CInit, 0, 0, 0);
        rstA = 1'b1;
        cyc("init_cycle", 0, CInit, 0, 0, 0);
        cyc("run_after_init", 0, CRun, 0, 0, 0);

        // Load-use on rs
        setEx(5'd5, 1, 1); setId(5'd5, 1, 5'd0, 0);
        cyc("load_use_rs", 0, CStl, 0, 0, 0);
        setEx(5'd0, 0, 0);
        cyc("after_load_use", 0, CRun, 1, 0, 0);
        // $0 never hazards
        setEx(5'd0, 1, 1); setId(5'd0, 1, 5'd0, 0);
        cyc("reg_zero", 0, CRun, 1, 0, 0);
        // Load-use on rt
        setEx(5'd7, 1, 1); setId(5'd1, 0, 5'd7, 1);
        cyc("load_use_rt", 0, CStl, 1, 0, 0);
        setEx(5'd0, 0, 0);
        cyc("after_rt", 0, CRun, 2, 0, 0);
        setEx(5'd7, 1, 1); setId(5'd0, 0, 5'd7, 0);
        cyc("rt_unused", 0, CRun, 2, 0, 0);
        setEx(5'd7, 1, 0); setId(5'd0, 0, 5'd7, 1);
        cyc("fwd_alu_ex", 0, CRun, 2, 0, 0);
        clr(); mem_wa = 5'd7; mem_w = 1'b1; setId(5'd7, 1, 5'd0, 0);
        cyc("fwd_mem", 0, CRun, 2, 0, 0);

        // Redirect wins over a simultaneous hazard
        clr(); setEx(5'd5, 1, 1); setId(5'd5, 1, 5'd0, 0); br = 1'b1;
        cyc("branch_plus_hz", 0, CRdr, 2, 0, 0);
        clr();
        cyc("after_branch", 0, CRun, 2, 1, 0);

        // Freeze during a hazard, then one stall cycle
        setEx(5'd9, 1, 1); setId(5'd9, 1, 5'd0, 0); mem_busy = 1'b1;
        cyc("freeze1", 0, CInit, 2, 1, 0);
        cyc("freeze2", 0, CInit, 2, 1, 0);
        cyc("freeze3", 0, CInit, 2, 1, 0);
        mem_busy = 1'b0;
        cyc("stall_after_freeze", 0, CStl, 2, 1, 0);
        clr();
        cyc("run_after_freeze", 0, CRun, 3, 1, 0);
        cpu_en = 1'b0;
        cyc("cpu_en_low", 0, CInit, 3, 1, 0);
        cpu_en = 1'b1;
        cyc("cpu_en_back", 0, CRun, 3, 1, 0);

        // Asynchronous reset in the middle of a stall
        setEx(5'd5, 1, 1); setId(5'd5, 1, 5'd0, 0);
        cyc("stall_before_rst", 0, CStl, 3, 1, 0);
        rstA = 1'b0;
        cyc("reset_mid_stall", 0, CInit, 0, 0, 0);

        // No-forwarding instance, MAX_STALL=2
        clr(); rstB = 1'b1;
        cyc("b_init", 1, CInit, 0, 0, 0);
        cyc("b_run", 1, CRun, 0, 0, 0);
        setEx(5'd3, 1, 0); setId(5'd0, 0, 5'd3, 1);
        cyc("b_raw_ex_1", 1, CStl, 0, 0, 0);
        setEx(5'd0, 0, 0); mem_wa = 5'd3; mem_w = 1'b1;
        cyc("b_raw_ex_2", 1, CStl, 1, 0, 0);
        clr();
        cyc("b_timeout_set", 1, CRun, 2, 0, 1);
        mem_wa = 5'd4; mem_w = 1'b1; setId(5'd4, 1, 5'd0, 0);
        cyc("b_raw_mem", 1, CStl, 2, 0, 1);
        clr();
        cyc("b_after_mem", 1, CRun, 3, 0, 1);
        mem_wa = 5'd4; mem_w = 1'b0; setId(5'd4, 1, 5'd0, 0);
        cyc("b_mem_nowrite", 1, CRun, 3, 0, 1);
        clr(); setEx(5'd6, 0, 0); setId(5'd6, 1, 5'd0, 0);
        cyc("b_ex_nowrite", 1, CRun, 3, 0, 1);
        allIssued = 1'b1;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL time_limit: issued=%0d, want 1", allIssued);
        $fatal(1, "time limit");
    end

endmodule
